rv_burst_initiator: RTL and testbench

Source (initiator) end of the single-beat valid/ready request interface; drives valid_out/data_out toward a busy-after-accept responder.
On a start pulse it issues a programmed burst of N requests with incrementing payload, honouring backpressure and an optional idle gap between beats.
A stall watchdog flags any responder that holds ready low longer than the interface guarantee.
Used as the stimulus/master side of the countdown responder and as a reusable request generator in the subsystem.

---
 rtl/rv_pkg.sv | 15 +
 rtl/rv_burst_initiator_if.sv | 22 ++
 rtl/rv_stall_watchdog.sv | 38 +++
 rtl/rv_burst_initiator.sv | 120 ++++++++++++
 tb/tb_rv_burst_initiator.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared state encoding and default constants for the valid/ready request link
package rv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } rv_state_t;

    localparam int RV_MAX_WAIT = 10;
    localparam int RV_DATA_W   = 8;
    localparam int RV_CNT_W    = 4;

endpackage

// File: rtl/rv_burst_initiator_if.sv
// rtl/rv_burst_initiator_if.sv - single-beat valid/ready request link between initiator and responder
interface rv_burst_initiator_if #(
    parameter int DATA_W = rv_pkg::RV_DATA_W
) ();

    logic              valid_out;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output valid_out,
        output data_out,
        input  ready_in
    );

    modport slave (
        input  valid_out,
        input  data_out,
        output ready_in
    );

endinterface

// File: rtl/rv_stall_watchdog.sv
// rtl/rv_stall_watchdog.sv - saturating stall counter with a sticky timeout flag
module rv_stall_watchdog
    import rv_pkg::*;
#(
    parameter int MAX_WAIT = RV_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_ready,
    input  logic i_clr,
    output logic o_timeout
);

    localparam int SW = $clog2(MAX_WAIT + 2);
    localparam logic [SW-1:0] LIMIT = SW'(MAX_WAIT + 1);

    logic [SW-1:0] r_stall_cnt;
    logic          r_timeout;

    // Counter parks at LIMIT so a very long stall never wraps back below it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (i_clr) begin
            r_stall_cnt <= '0;
        end else if (i_valid && !i_ready && (r_stall_cnt != LIMIT)) begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
            if ((r_stall_cnt + SW'(1)) == LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/rv_burst_initiator.sv
// rtl/rv_burst_initiator.sv - issues a programmed burst of incrementing requests on a valid/ready link
module rv_burst_initiator
    import rv_pkg::*;
#(
    parameter int DATA_W     = RV_DATA_W,
    parameter int MAX_WAIT   = RV_MAX_WAIT,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = RV_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [CNT_W-1:0]         i_num_req,
    input  logic [DATA_W-1:0]        i_base_data,
    rv_burst_initiator_if.master     bus,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_issued_count,
    output logic                     o_timeout_err
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    rv_state_t          r_state;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_num;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic               w_hs;
    logic               w_clr;
    logic               w_timeout;

    assign w_hs  = r_valid && bus.ready_in;
    // Outside SEND the watchdog is held clear, so every SEND entry starts from zero.
    assign w_clr = w_hs || (r_state != SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_num     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_num_req != '0) begin
                            r_num   <= i_num_req;
                            r_data  <= i_base_data;
                            r_count <= '0;
                            r_valid <= 1'b1;
                            r_state <= SEND;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        r_count <= r_count + CNT_W'(1);
                        r_data  <= r_data + DATA_W'(1);
                        if ((r_count + CNT_W'(1)) == r_num) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (GAP_CYCLES > 0) begin
                            r_valid   <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_valid <= 1'b1;
                        r_state <= SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rv_stall_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (r_valid),
        .i_ready   (bus.ready_in),
        .i_clr     (w_clr),
        .o_timeout (w_timeout)
    );

    assign bus.valid_out  = r_valid;
    assign bus.data_out   = r_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_issued_count = r_count;
    assign o_timeout_err  = w_timeout;

endmodule

// File: tb/tb_rv_burst_initiator.sv
// tb/tb_rv_burst_initiator.sv - directed vector bench for rv_burst_initiator
module tb_rv_burst_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [3:0] num0, num1;
    logic [7:0] base0, base1;
    logic       busy0, busy1, done0, done1, to0, to1;
    logic [3:0] cnt0, cnt1;

    int n_checks = 0;
    int n_errors = 0;

    rv_burst_initiator_if #(.DATA_W(8)) bus0 ();
    rv_burst_initiator_if #(.DATA_W(8)) bus1 ();

    rv_burst_initiator #(.DATA_W(8), .MAX_WAIT(10), .GAP_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .i_start(start0), .i_num_req(num0), .i_base_data(base0),
        .bus(bus0), .o_busy(busy0), .o_done(done0), .o_issued_count(cnt0), .o_timeout_err(to0)
    );

    rv_burst_initiator #(.DATA_W(8), .MAX_WAIT(10), .GAP_CYCLES(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_num_req(num1), .i_base_data(base1),
        .bus(bus1), .o_busy(busy1), .o_done(done1), .o_issued_count(cnt1), .o_timeout_err(to1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] num;
        logic [7:0] base;
        logic       ready;
        logic       valid;
        logic       busy;
        logic       done;
        logic       to;
        logic [7:0] data;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic v, input logic b, input logic d,
                        input logic t, input logic [7:0] data, input logic [3:0] cnt);
        chk({tag, ".valid"}, 32'(bus0.valid_out), 32'(v));
        chk({tag, ".busy"},  32'(busy0), 32'(b));
        chk({tag, ".done"},  32'(done0), 32'(d));
        chk({tag, ".timeout"}, 32'(to0), 32'(t));
        chk({tag, ".data"},  32'(bus0.data_out), 32'(data));
        chk({tag, ".count"}, 32'(cnt0), 32'(cnt));
    endtask

    task automatic chk1(input string tag, input logic v, input logic b, input logic d,
                        input logic [7:0] data, input logic [3:0] cnt);
        chk({tag, ".valid"}, 32'(bus1.valid_out), 32'(v));
        chk({tag, ".busy"},  32'(busy1), 32'(b));
        chk({tag, ".done"},  32'(done1), 32'(d));
        chk({tag, ".data"},  32'(bus1.data_out), 32'(data));
        chk({tag, ".count"}, 32'(cnt1), 32'(cnt));
        chk({tag, ".timeout"}, 32'(to1), 32'(0));
    endtask

    initial begin
        //          rst start num  base  rdy  valid busy done to  data   cnt
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'd3, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 4'd1};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 4'd2};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 4'd3};
        vecs[5]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 4'd3};
        vecs[6]  = '{1'b0, 1'b1, 4'd0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 4'd3};
        vecs[7]  = '{1'b0, 1'b1, 4'd5, 8'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 4'd3};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 4'd3};
        vecs[9]  = '{1'b0, 1'b1, 4'd2, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 4'd0};
        vecs[10] = '{1'b0, 1'b1, 4'd7, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 4'd0};
        vecs[11] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 4'd1};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h42, 4'd2};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 4'd2};

        rst = 1'b1;
        start0 = 1'b0; num0 = '0; base0 = '0; bus0.ready_in = 1'b0;
        start1 = 1'b0; num1 = '0; base1 = '0; bus1.ready_in = 1'b0;
        #2;

        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst;
            start0 = vecs[i].start;
            num0 = vecs[i].num;
            base0 = vecs[i].base;
            bus0.ready_in = vecs[i].ready;
            step();
            chk0($sformatf("vec%0d", i), vecs[i].valid, vecs[i].busy, vecs[i].done,
                 vecs[i].to, vecs[i].data, vecs[i].cnt);
        end

        // Countdown-style responder: busy 10 cycles after each accept
        start0 = 1'b1; num0 = 4'd2; base0 = 8'hA0; bus0.ready_in = 1'b1;
        step();
        chk0("cd.first", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 4'd0);
        start0 = 1'b0;
        step();
        chk0("cd.hs1", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 4'd1);
        bus0.ready_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk0($sformatf("cd.stall%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 4'd1);
        end
        bus0.ready_in = 1'b1;
        step();
        chk0("cd.hs2", 1'b0, 1'b1, 1'b1, 1'b0, 8'hA2, 4'd2);
        bus0.ready_in = 1'b0;
        step();
        chk0("cd.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2, 4'd2);

        // Stall past the watchdog limit
        start0 = 1'b1; num0 = 4'd1; base0 = 8'h55; bus0.ready_in = 1'b0;
        step();
        chk0("to.start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 4'd0);
        start0 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk0($sformatf("to.stall%0d", k), 1'b1, 1'b1, 1'b0, (k >= 11), 8'h55, 4'd0);
        end
        bus0.ready_in = 1'b1;
        step();
        chk0("to.hs", 1'b0, 1'b1, 1'b1, 1'b1, 8'h56, 4'd1);
        bus0.ready_in = 1'b0;
        step();
        chk0("to.idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'h56, 4'd1);

        // Gap of two idle cycles and payload wrap
        start1 = 1'b1; num1 = 4'd2; base1 = 8'hFF; bus1.ready_in = 1'b1;
        step();
        chk1("gap.beat0", 1'b1, 1'b1, 1'b0, 8'hFF, 4'd0);
        start1 = 1'b0;
        step();
        chk1("gap.low1", 1'b0, 1'b1, 1'b0, 8'h00, 4'd1);
        step();
        chk1("gap.low2", 1'b0, 1'b1, 1'b0, 8'h00, 4'd1);
        step();
        chk1("gap.beat1", 1'b1, 1'b1, 1'b0, 8'h00, 4'd1);
        step();
        chk1("gap.done", 1'b0, 1'b1, 1'b1, 8'h01, 4'd2);
        step();
        chk1("gap.idle", 1'b0, 1'b0, 1'b0, 8'h01, 4'd2);

        // Reset mid-burst, then a normal burst
        start0 = 1'b1; num0 = 4'd3; base0 = 8'h20; bus0.ready_in = 1'b1;
        step();
        start0 = 1'b0;
        step();
        chk0("rst.pre", 1'b1, 1'b1, 1'b0, 1'b1, 8'h21, 4'd1);
        rst = 1'b1;
        step();
        chk0("rst.post", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
        rst = 1'b0;
        start0 = 1'b1; num0 = 4'd1; base0 = 8'h30;
        step();
        chk0("rst.restart", 1'b1, 1'b1, 1'b0, 1'b0, 8'h30, 4'd0);
        start0 = 1'b0;
        step();
        chk0("rst.done", 1'b0, 1'b1, 1'b1, 1'b0, 8'h31, 4'd1);
        step();
        chk0("rst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h31, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
